// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial receive path.
package serial_pkg;

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned DEF_MAX_BYTES = 6;

  // Frame length as actually received: 0 means 1, anything above max_n means max_n.
  function automatic logic [2:0] clamp_nbytes(input logic [2:0] n, input logic [2:0] max_n);
    if (n == 3'd0) return 3'd1;
    if (n > max_n) return max_n;
    return n;
  endfunction

endpackage

// File: rtl/serial_sync.sv
// Input synchroniser for the serial line; resets to the idle (high) level.
module serial_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '1;
    else     chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/serial_rx.sv
// Serial frame receiver: start bit, 8*N data bits LSB first, stop bit;
// committed bytes are popped one at a time through valid/get.
module serial_rx
  import serial_pkg::*;
#(
  parameter int unsigned MAX_BYTES   = DEF_MAX_BYTES,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [2:0] nbytes,
  input  logic       get,
  output logic [7:0] data,
  output logic       valid,
  output logic [2:0] remaining,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned BUF_W = BYTE_W * MAX_BYTES;
  localparam logic [2:0]  MAXN  = 3'(MAX_BYTES);

  state_t           state;
  logic             rx_s;
  logic [5:0]       bitcnt;
  logic [2:0]       nlat;
  logic [BUF_W-1:0] shreg;
  logic [BUF_W-1:0] buffer;
  logic [2:0]       ptr;
  logic [2:0]       ptr_n;
  logic             commit;
  logic             pop;

  serial_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign valid  = (remaining != 3'd0);
  assign busy   = (state != IDLE);
  assign commit = (state == STOP) && rx_s;
  assign pop    = valid && get;
  assign ptr_n  = ptr + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bitcnt    <= '0;
      nlat      <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state  <= DATA;
            nlat   <= clamp_nbytes(nbytes, MAXN);
            bitcnt <= '0;
            shreg  <= '0;
          end
        end
        DATA: begin
          shreg[bitcnt] <= rx_s;
          bitcnt        <= bitcnt + 6'd1;
          if (bitcnt == ({nlat, 3'b000} - 6'd1)) state <= STOP;
        end
        STOP: begin
          state <= IDLE;
          if (!rx_s) frame_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A commit takes priority over a pop landing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer    <= '0;
      remaining <= '0;
      ptr       <= '0;
      data      <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit) begin
        buffer    <= shreg;
        remaining <= nlat;
        ptr       <= '0;
        data      <= shreg[BYTE_W-1:0];
        overrun   <= (remaining != 3'd0);
      end else if (pop) begin
        ptr       <= ptr_n;
        remaining <= remaining - 3'd1;
        if (remaining != 3'd1) data <= buffer[{ptr_n, 3'b000} +: BYTE_W];
      end
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: table of single frames plus hand-written corner sequences.
module tb_serial_rx;

  localparam int unsigned S  = 2;
  localparam int unsigned MB = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [2:0] nbytes;
  logic       get;
  logic [7:0] data;
  logic       valid;
  logic [2:0] remaining;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int checks   = 0;
  int failures = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

  serial_rx #(.MAX_BYTES(MB), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .nbytes    (nbytes),
    .get       (get),
    .data      (data),
    .valid     (valid),
    .remaining (remaining),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overrun)   ovr_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [2:0]  nb;       // value on the nbytes port
    logic [2:0]  nwire;    // bytes actually sent on the line
    logic [47:0] payload;  // byte 0 in bits 7:0
    logic        stopb;
    logic [2:0]  exp_rem;
    logic [7:0]  exp_data;
    logic        exp_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick();
  endtask

  task automatic send_frame(input logic [47:0] payload, input int unsigned nwire, input logic stopb);
    send_bit(1'b0);
    for (int unsigned i = 0; i < nwire * 8; i++) send_bit(payload[i]);
    send_bit(stopb);
    rx = 1'b1;
  endtask

  // Pop n bytes, checking the head byte and count before each pop.
  task automatic drain(input string name, input logic [47:0] payload, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      check({name, " data"}, 32'(data), 32'(payload[i*8 +: 8]));
      check({name, " remaining"}, 32'(remaining), 32'(n - i));
      get = 1'b1;
      tick();
      get = 1'b0;
    end
    check({name, " valid after drain"}, 32'(valid), 32'd0);
    check({name, " data held"}, 32'(data), 32'(payload[(n-1)*8 +: 8]));
  endtask

  initial begin
    int ovr0;
    int ferr0;

    vecs[0] = '{nb:3'd2, nwire:3'd2, payload:48'h3CA5,          stopb:1'b1, exp_rem:3'd2, exp_data:8'hA5, exp_ferr:1'b0};
    vecs[1] = '{nb:3'd1, nwire:3'd1, payload:48'hFF,            stopb:1'b0, exp_rem:3'd0, exp_data:8'h3C, exp_ferr:1'b1};
    vecs[2] = '{nb:3'd1, nwire:3'd1, payload:48'h5A,            stopb:1'b1, exp_rem:3'd1, exp_data:8'h5A, exp_ferr:1'b0};
    vecs[3] = '{nb:3'd6, nwire:3'd6, payload:48'h060504030201,  stopb:1'b1, exp_rem:3'd6, exp_data:8'h01, exp_ferr:1'b0};
    vecs[4] = '{nb:3'd7, nwire:3'd6, payload:48'h060504030201,  stopb:1'b1, exp_rem:3'd6, exp_data:8'h01, exp_ferr:1'b0};
    vecs[5] = '{nb:3'd0, nwire:3'd1, payload:48'h81,            stopb:1'b1, exp_rem:3'd1, exp_data:8'h81, exp_ferr:1'b0};
    vecs[6] = '{nb:3'd3, nwire:3'd3, payload:48'hC0FFEE,        stopb:1'b1, exp_rem:3'd3, exp_data:8'hEE, exp_ferr:1'b0};

    rst = 1'b1; rx = 1'b1; get = 1'b0; nbytes = 3'd1;
    tick(); tick();
    check("reset data",      32'(data),      32'd0);
    check("reset valid",     32'(valid),     32'd0);
    check("reset remaining", 32'(remaining), 32'd0);
    check("reset busy",      32'(busy),      32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    check("reset overrun",   32'(overrun),   32'd0);
    rst = 1'b0;
    tick(); tick();

    for (int unsigned v = 0; v < 7; v++) begin
      nbytes = vecs[v].nb;
      send_frame(vecs[v].payload, 32'(vecs[v].nwire), vecs[v].stopb);
      for (int unsigned k = 0; k < S - 1; k++) tick();
      check($sformatf("v%0d busy in stop", v),   32'(busy),  32'd1);
      check($sformatf("v%0d valid early", v),    32'(valid), 32'd0);
      tick();
      check($sformatf("v%0d valid", v),          32'(valid),     32'(vecs[v].exp_rem != 3'd0));
      check($sformatf("v%0d remaining", v),      32'(remaining), 32'(vecs[v].exp_rem));
      check($sformatf("v%0d data", v),           32'(data),      32'(vecs[v].exp_data));
      check($sformatf("v%0d frame_err", v),      32'(frame_err), 32'(vecs[v].exp_ferr));
      check($sformatf("v%0d overrun", v),        32'(overrun),   32'd0);
      check($sformatf("v%0d busy after", v),     32'(busy),      32'd0);
      tick();
      check($sformatf("v%0d frame_err pulse", v), 32'(frame_err), 32'd0);
      if (vecs[v].exp_rem != 3'd0)
        drain($sformatf("v%0d", v), vecs[v].payload, 32'(vecs[v].exp_rem));
      tick();
    end

    // Back-to-back frames, first byte left unread.
    nbytes = 3'd1;
    ovr0 = ovr_cnt;
    send_frame(48'h11, 1, 1'b1);
    send_frame(48'h22, 1, 1'b1);
    for (int unsigned k = 0; k < S; k++) tick();
    check("b2b overrun",   32'(overrun),   32'd1);
    check("b2b data",      32'(data),      32'h22);
    check("b2b remaining", 32'(remaining), 32'd1);
    tick();
    check("b2b overrun count", 32'(ovr_cnt - ovr0), 32'd1);
    drain("b2b", 48'h22, 1);

    // Pop requested in the very cycle a new frame commits.
    send_frame(48'hAA, 1, 1'b1);
    for (int unsigned k = 0; k < S; k++) tick();
    check("pc first data", 32'(data), 32'hAA);
    send_frame(48'hBB, 1, 1'b1);
    for (int unsigned k = 0; k < S - 1; k++) tick();
    get = 1'b1;
    tick();
    get = 1'b0;
    check("pc overrun",   32'(overrun),   32'd1);
    check("pc data",      32'(data),      32'hBB);
    check("pc remaining", 32'(remaining), 32'd1);
    drain("pc", 48'hBB, 1);

    // Reset mid-frame while a byte is still buffered.
    send_frame(48'h77, 1, 1'b1);
    for (int unsigned k = 0; k < S; k++) tick();
    check("mr pre valid", 32'(valid), 32'd1);
    send_bit(1'b0);
    for (int unsigned i = 0; i < 6; i++) send_bit(1'b0);
    rst = 1'b1;
    #1;
    check("mr data",      32'(data),      32'd0);
    check("mr valid",     32'(valid),     32'd0);
    check("mr remaining", 32'(remaining), 32'd0);
    check("mr busy",      32'(busy),      32'd0);
    tick();
    rx = 1'b1;
    rst = 1'b0;
    ferr0 = ferr_cnt;
    ovr0  = ovr_cnt;
    for (int unsigned k = 0; k < 12; k++) tick();
    check("mr quiet frame_err", 32'(ferr_cnt - ferr0), 32'd0);
    check("mr quiet overrun",   32'(ovr_cnt - ovr0),   32'd0);
    check("mr quiet valid",     32'(valid),            32'd0);
    check("mr quiet busy",      32'(busy),             32'd0);
    send_frame(48'hC3, 1, 1'b1);
    for (int unsigned k = 0; k < S; k++) tick();
    check("mr next data",      32'(data),      32'hC3);
    check("mr next remaining", 32'(remaining), 32'd1);
    check("mr next overrun",   32'(overrun),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
- Receive end of the single-wire, one-bit-per-clock serial link driven by the team's byte-loading serial transmitter.
- Frame format, all on `clk`, one bit per cycle:
  - idle high;
  - one start bit (0);
  - 8*N data bits, LSB of byte 0 first;
  - line returns high (stop).
- Synchronises `rx`, deserialises up to MAX_BYTES bytes into a holding buffer, and hands them to the consumer one byte at a time through a valid/get pop interface.

Parameters:
- MAX_BYTES, 6, maximum bytes per frame. Buffer width is 8*MAX_BYTES bits.
- SYNC_STAGES, 2, number of flops in the `rx` synchroniser, minimum 2.

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, idle high.
- nbytes  input  3  frame length in bytes. Sampled on start-bit detection. 0 is treated as 1; values above MAX_BYTES are treated as MAX_BYTES.
- get  input  1  pop request. Acts only when `valid`=1.
- data  output  8  current head byte of the buffer.
- valid  output  1  buffer holds at least one unread byte.
- remaining  output  3  count of unread bytes, 0..MAX_BYTES.
- busy  output  1  high in DATA and STOP states.
- frame_err  output  1  one-cycle pulse: stop bit sampled low, frame discarded.
- overrun  output  1  one-cycle pulse: committed frame overwrote unread bytes.

Behaviour:
- **Reset** (async, active-high; effective immediately, including mid-frame):
  - state=IDLE; synchroniser flops=1, so release cannot create a false start;
  - shift register=0, buffer=0, read pointer=0, remaining=0;
  - data=0, valid=0, busy=0, frame_err=0, overrun=0.
- **Synchroniser:** `rx_s` is `rx` delayed by SYNC_STAGES cycles. All decisions use `rx_s`.
- **IDLE:**
  - `rx_s`=0 → go to DATA;
  - latch total = 8*clamp(nbytes); clear the bit counter and shift register.
- **DATA:**
  - each cycle, store `rx_s` at shift-register bit index `bitcnt`, then increment `bitcnt`;
  - when `bitcnt` = total-1 (last bit stored this cycle) → go to STOP;
  - bits at index ≥ total stay 0.
- **STOP** (sample `rx_s` once):
  - `rx_s`=1 → commit: buffer ← shift register, remaining ← clamp(nbytes) latched at start, read pointer ← 0;
    - if remaining ≠ 0 in the commit cycle (before commit, regardless of `get`), pulse `overrun`;
  - `rx_s`=0 → discard the frame; buffer, remaining and pointer unchanged; pulse `frame_err`;
  - either outcome → go to IDLE.
  - The next start bit is accepted from the cycle after STOP. Back-to-back frames with a single stop cycle are supported.
- **Latency:** stop bit on `rx` → `valid` high after SYNC_STAGES+1 cycles.
  - Pulses (`frame_err`, `overrun`) are registered and coincide with that first cycle.
- **Pop:**
  - `valid` = (remaining ≠ 0);
  - `data` = buffer byte[read pointer], registered view updated with pointer/buffer;
  - `valid`&&`get` → pointer+1 and remaining-1 next cycle;
  - last byte popped → `valid`=0, `data` holds its last value;
  - `get` with `valid`=0 is ignored.
- **Simultaneous commit and `get`:** commit wins, the pop is dropped, and `overrun` pulses.
- **Width rules:** `bitcnt` is 6 bits, max 47. The pointer never wraps; remaining gates it.

Decomposition:
- Package `serial_pkg`:
  - state enum {IDLE, DATA, STOP};
  - BYTE_W=8;
  - MAX_BYTES default;
  - clamp function for `nbytes`.
- Sub-module `serial_sync`:
  - parameterised SYNC_STAGES flop chain;
  - async-reset to 1.

Test Plan:
- nbytes=2, frame 0 / A5 bits 1,0,1,0,0,1,0,1 / 3C bits 0,0,1,1,1,1,0,0 / 1 → `valid` rises SYNC_STAGES+1 cycles after stop, remaining=2, data=A5; `get` → data=3C, remaining=1; `get` → `valid`=0, no error pulses.
- nbytes=1, byte FF, stop bit driven 0 → `frame_err` one-cycle pulse, `valid` stays 0, `busy` drops, next good frame with byte 5A → data=5A.
- nbytes=6 with bytes 01..06, then pop all six → data sequence 01,02,03,04,05,06, remaining counts 6→0; nbytes=7 behaves identically to 6.
- Two frames of 1 byte (11 then 22), first byte never popped, second frame sent back-to-back after one stop cycle → `overrun` pulses once, data=22, remaining=1.
- `rst` asserted at data bit 5 of a frame, deasserted with `rx`=1 → all outputs 0 immediately, no `frame_err`/`overrun`/`valid` afterwards, next clean frame 0xC3 received correctly.
- `get` asserted in the exact commit cycle with 1 unread byte (AA) and new byte BB → `overrun` pulse, data=BB, remaining=1.
